// File: rtl/wb_port_arbiter_if.sv
// Bundle of writeback-stage, long-latency-unit and register-file write-port signals
// shared between the write-port arbiter and its surroundings.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface wb_port_arbiter_if #(
   parameter int WIDTH = `WORD_SIZE,
   parameter int DEPTH = 2
);
   logic                   RegWriteW;
   logic [4:0]             RdW;
   logic [WIDTH-1:0]       ResultW;
   logic                   LUValid;
   logic [4:0]             LURd;
   logic [WIDTH-1:0]       LUData;
   logic                   LUReady;
   logic                   RegWriteRF;
   logic [4:0]             RdRF;
   logic [WIDTH-1:0]       WriteDataRF;
   logic [4:0]             RdWH;
   logic                   RegWriteWH;
   logic                   StallReq;
   logic [$clog2(DEPTH):0] FifoCount;

   modport slave (
      input  RegWriteW, RdW, ResultW, LUValid, LURd, LUData,
      output LUReady, RegWriteRF, RdRF, WriteDataRF, RdWH, RegWriteWH, StallReq, FifoCount
   );

   modport master (
      output RegWriteW, RdW, ResultW, LUValid, LURd, LUData,
      input  LUReady, RegWriteRF, RdRF, WriteDataRF, RdWH, RegWriteWH, StallReq, FifoCount
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results are
// buffered and drained into idle port cycles, starvation raises a stall request.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_port_arbiter #(
   parameter int WIDTH        = `WORD_SIZE,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   wb_port_arbiter_if.slave  bus
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam logic [3:0]      LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [CNTW-1:0] FULLCNT = CNTW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      STARVED = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [3:0]       starveCnt_r, starveCnt_s;
   logic [PTRW-1:0]  headPtr_r, tailPtr_r;
   logic [CNTW-1:0]  count_r, count_s;
   logic [4:0]       rdMem_r [DEPTH];
   logic [WIDTH-1:0] dataMem_r [DEPTH];

   logic             pv_s, empty_s, full_s, push_s, pop_s;
   logic             wrEn_s;
   logic [4:0]       wrRd_s;
   logic [WIDTH-1:0] wrData_s;

   // Arbitration and FIFO handshake; reset forces the port idle without waiting for a clock
   always_comb begin
      pv_s     = bus.RegWriteW & (bus.RdW != 5'd0);
      empty_s  = (count_r == '0);
      full_s   = (count_r == FULLCNT);
      pop_s    = ~pv_s & ~empty_s & ~rst;
      push_s   = bus.LUValid & ~full_s & (bus.LURd != 5'd0) & ~rst;
      wrEn_s   = 1'b0;
      wrRd_s   = 5'd0;
      wrData_s = '0;
      if (pv_s && !rst) begin
         wrEn_s   = 1'b1;
         wrRd_s   = bus.RdW;
         wrData_s = bus.ResultW;
      end else if (pop_s) begin
         wrEn_s   = 1'b1;
         wrRd_s   = rdMem_r[headPtr_r];
         wrData_s = dataMem_r[headPtr_r];
      end else begin
         wrEn_s   = 1'b0;
      end
   end

   assign bus.RegWriteRF  = wrEn_s;
   assign bus.RdRF        = wrRd_s;
   assign bus.WriteDataRF = wrData_s;
   assign bus.RegWriteWH  = wrEn_s;
   assign bus.RdWH        = wrRd_s;
   assign bus.LUReady     = ~full_s;
   assign bus.FifoCount   = count_r;
   assign bus.StallReq    = (state_r == STARVED);

   // Next FIFO occupancy from the push/pop pair
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CNTW'(1);
         2'b01:   count_s = count_r - CNTW'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         headPtr_r <= '0;
         tailPtr_r <= '0;
         count_r   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rdMem_r[i]   <= 5'd0;
            dataMem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            rdMem_r[tailPtr_r]   <= bus.LURd;
            dataMem_r[tailPtr_r] <= bus.LUData;
            tailPtr_r            <= tailPtr_r + PTRW'(1);
         end
         if (pop_s) begin
            headPtr_r <= headPtr_r + PTRW'(1);
         end
         count_r <= count_s;
      end
   end

   // Starvation FSM next state and counter
   always_comb begin
      state_s     = state_r;
      starveCnt_s = starveCnt_r;
      case (state_r)
         IDLE: begin
            starveCnt_s = 4'd0;
            if (push_s) begin
               state_s = PENDING;
            end else begin
               state_s = IDLE;
            end
         end
         PENDING: begin
            if (pop_s) begin
               starveCnt_s = 4'd0;
               state_s     = (count_s == '0) ? IDLE : PENDING;
            end else if (!empty_s) begin
               starveCnt_s = starveCnt_r + 4'd1;
               state_s     = ((starveCnt_r + 4'd1) >= LIMIT) ? STARVED : PENDING;
            end else begin
               starveCnt_s = 4'd0;
               state_s     = push_s ? PENDING : IDLE;
            end
         end
         STARVED: begin
            if (pop_s) begin
               starveCnt_s = 4'd0;
               state_s     = (count_s == '0) ? IDLE : PENDING;
            end else begin
               starveCnt_s = (starveCnt_r < LIMIT) ? (starveCnt_r + 4'd1) : LIMIT;
               state_s     = STARVED;
            end
         end
         default: begin
            starveCnt_s = 4'd0;
            state_s     = IDLE;
         end
      endcase
   end

   // FSM state and starvation counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         starveCnt_r <= 4'd0;
      end else begin
         state_r     <= state_s;
         starveCnt_r <= starveCnt_s;
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter with a scoreboard of buffered LU results
// and a hand-written asynchronous mid-operation reset sequence.
module tb_wb_port_arbiter;
   localparam int W = 32;

   typedef struct {
      logic          regWriteW;
      logic [4:0]    rdW;
      logic [W-1:0]  resultW;
      logic          luValid;
      logic [4:0]    luRd;
      logic [W-1:0]  luData;
      logic          expWe;
      logic [4:0]    expRd;
      logic [W-1:0]  expData;
      logic          expReady;
      logic          expStall;
      logic [1:0]    expCount;
   } vec_t;

   typedef struct {
      logic [4:0]   rd;
      logic [W-1:0] data;
   } sb_t;

   logic clk;
   logic rst;
   int   testsRun;
   int   failCount;
   vec_t vecs[$];
   sb_t  sbQ[$];

   wb_port_arbiter_if #(.WIDTH(W), .DEPTH(2)) wbIf();

   wb_port_arbiter #(.WIDTH(W), .DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (wbIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic rw, input logic [4:0] rd, input logic [W-1:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [W-1:0] ldat,
                         input logic we, input logic [4:0] erd, input logic [W-1:0] edat,
                         input logic rdy, input logic stall, input logic [1:0] cnt);
      vec_t v;
      v.regWriteW = rw;  v.rdW = rd;   v.resultW = res;
      v.luValid   = lv;  v.luRd = lrd; v.luData  = ldat;
      v.expWe     = we;  v.expRd = erd; v.expData = edat;
      v.expReady  = rdy; v.expStall = stall; v.expCount = cnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rw, input logic [4:0] rd, input logic [W-1:0] res,
                        input logic lv, input logic [4:0] lrd, input logic [W-1:0] ldat);
      wbIf.RegWriteW = rw;  wbIf.RdW  = rd;  wbIf.ResultW = res;
      wbIf.LUValid   = lv;  wbIf.LURd = lrd; wbIf.LUData  = ldat;
   endtask

   task automatic checkOutputs(input string tag, input logic we, input logic [4:0] rd,
                               input logic [W-1:0] data, input logic rdy, input logic stall,
                               input logic [1:0] cnt);
      check({tag, " RegWriteRF"},  32'(wbIf.RegWriteRF), 32'(we));
      check({tag, " RdRF"},        32'(wbIf.RdRF),       32'(rd));
      check({tag, " WriteDataRF"}, wbIf.WriteDataRF,     data);
      check({tag, " RegWriteWH"},  32'(wbIf.RegWriteWH), 32'(we));
      check({tag, " RdWH"},        32'(wbIf.RdWH),       32'(rd));
      check({tag, " LUReady"},     32'(wbIf.LUReady),    32'(rdy));
      check({tag, " StallReq"},    32'(wbIf.StallReq),   32'(stall));
      check({tag, " FifoCount"},   32'(wbIf.FifoCount),  32'(cnt));
   endtask

   initial begin
      testsRun  = 0;
      failCount = 0;

      //     rw  rd     result        lv  lrd     ldata         we  erd    edata         rdy stl cnt
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 2'd0);
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 2'd0);
      addVec(1, 5'd5,  32'h0000_00AA, 0, 5'd0, 32'h0,        1, 5'd5,  32'h0000_00AA, 1, 0, 2'd0);
      addVec(1, 5'd0,  32'h0000_0055, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 2'd0);
      addVec(0, 5'd0,  32'h0,        1, 5'd7,  32'h0000_1234, 0, 5'd0, 32'h0,        1, 0, 2'd0);
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  32'h0000_1234, 1, 0, 2'd1);
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 2'd0);
      addVec(0, 5'd0,  32'h0,        1, 5'd0,  32'h0000_DEAD, 0, 5'd0, 32'h0,        1, 0, 2'd0);
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 2'd0);
      addVec(1, 5'd3,  32'h0000_0033, 1, 5'd8, 32'h0000_0800, 1, 5'd3, 32'h0000_0033, 1, 0, 2'd0);
      addVec(1, 5'd4,  32'h0000_0044, 1, 5'd9, 32'h0000_0900, 1, 5'd4, 32'h0000_0044, 1, 0, 2'd1);
      addVec(1, 5'd6,  32'h0000_0066, 1, 5'd10, 32'h0000_0A00, 1, 5'd6, 32'h0000_0066, 0, 0, 2'd2);
      addVec(0, 5'd0,  32'h0,        1, 5'd10, 32'h0000_0A00, 1, 5'd8, 32'h0000_0800, 0, 0, 2'd2);
      addVec(0, 5'd0,  32'h0,        1, 5'd10, 32'h0000_0A00, 1, 5'd9, 32'h0000_0900, 1, 0, 2'd1);
      for (int k = 0; k < 4; k++) begin
         addVec(1, 5'd1, 32'h0000_0011, 0, 5'd0, 32'h0,    1, 5'd1,  32'h0000_0011, 1, 0, 2'd1);
      end
      for (int k = 0; k < 2; k++) begin
         addVec(1, 5'd1, 32'h0000_0011, 0, 5'd0, 32'h0,    1, 5'd1,  32'h0000_0011, 1, 1, 2'd1);
      end
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd10, 32'h0000_0A00, 1, 1, 2'd1);
      addVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 2'd0);

      rst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutputs("reset", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 2'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i]) begin
         vec_t v;
         string tag;
         v   = vecs[i];
         tag = $sformatf("v%0d", i);
         drive(v.regWriteW, v.rdW, v.resultW, v.luValid, v.luRd, v.luData);
         if (v.luValid && v.expReady && (v.luRd != 5'd0)) begin
            sbQ.push_back('{rd: v.luRd, data: v.luData});
         end
         @(negedge clk);
         checkOutputs(tag, v.expWe, v.expRd, v.expData, v.expReady, v.expStall, v.expCount);
         if (v.expWe && !(v.regWriteW && (v.rdW != 5'd0))) begin
            if (sbQ.size() == 0) begin
               testsRun++;
               failCount++;
               $display("FAIL %s sb: FIFO write seen with nothing buffered", tag);
            end else begin
               sb_t e;
               e = sbQ.pop_front();
               check({tag, " sb rd"},   32'(wbIf.RdRF), 32'(e.rd));
               check({tag, " sb data"}, wbIf.WriteDataRF, e.data);
            end
         end
         @(posedge clk);
         #1;
      end
      check("sb drained", 32'(sbQ.size()), 32'd0);

      // Fill the FIFO under continuous pipeline writes until starvation is flagged
      drive(1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd11, 32'h0000_000B);
      @(posedge clk);
      #1 drive(1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd12, 32'h0000_000C);
      @(posedge clk);
      #1 drive(1'b1, 5'd2, 32'h0000_0022, 1'b0, 5'd0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (wbIf.StallReq) break;
      end
      check("pre-rst StallReq",  32'(wbIf.StallReq),  32'd1);
      check("pre-rst FifoCount", 32'(wbIf.FifoCount), 32'd2);
      check("pre-rst LUReady",   32'(wbIf.LUReady),   32'd0);

      #1 rst = 1'b1;
      sbQ.delete();
      #1;
      check("async FifoCount",  32'(wbIf.FifoCount),  32'd0);
      check("async StallReq",   32'(wbIf.StallReq),   32'd0);
      check("async RegWriteRF", 32'(wbIf.RegWriteRF), 32'd0);
      check("async RdRF",       32'(wbIf.RdRF),       32'd0);
      check("async LUReady",    32'(wbIf.LUReady),    32'd1);

      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutputs("post-rst", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
